high_priority_status_tx: RTL and testbench

Builds and transmits the hardware-to-PC High Priority Status UDP packet (source/destination port 1025) that answers the PC's High Priority C&C stream. Snapshots PTT/key/PLL/overload/power/voltage/user-input status, prefixes a 32-bit sequence number, and streams a fixed 60-byte payload one byte per clock to the Ethernet UDP transmit arbiter through a request/grant handshake. Sends periodically while `run` is high and, optionally, immediately on a status change.

---
 rtl/high_priority_status_tx.sv | 140 ++++++++++++++
 tb/tb_high_priority_status_tx.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/high_priority_status_tx.sv
// high_priority_status_tx: builds and streams the 60-byte High Priority Status UDP payload.
// Define HP_STATUS_EVENT_EN to also send on status changes or new overload bits.
module high_priority_status_tx #(
    parameter logic [15:0] port    = 16'd1025,
    parameter int          PKT_LEN = 60,
    parameter int          PERIOD  = 122880
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        run,
    input  logic        PTT,
    input  logic        Dot,
    input  logic        Dash,
    input  logic        pll_locked,
    input  logic [7:0]  ADC_overload,
    input  logic [15:0] exciter_power,
    input  logic [15:0] FWD_power,
    input  logic [15:0] REV_power,
    input  logic [15:0] supply_volts,
    input  logic [7:0]  user_inputs,
    output logic        tx_request,
    input  logic        tx_grant,
    output logic [15:0] to_port,
    output logic [15:0] udp_tx_length,
    output logic [7:0]  udp_tx_data,
    output logic        udp_tx_valid,
    output logic        udp_tx_last
);
    localparam int IW = $clog2(PKT_LEN);
    localparam int TW = $clog2(PERIOD);

    typedef enum logic [1:0] {IDLE, REQUEST, SEND} state_t;

    state_t        state, next;
    logic [TW-1:0] timer;
    logic [IW-1:0] idx;
    logic [31:0]   seq;
    logic [7:0]    ovl, ovl_s, status_s, user_s;
    logic [15:0]   exc_s, fwd_s, rev_s, volts_s;
    logic          pending, run_d, grab, wrap, trig;

    assign to_port       = port;
    assign udp_tx_length = 16'(PKT_LEN);
    assign wrap          = timer == TW'(PERIOD - 1);

`ifdef HP_STATUS_EVENT_EN
    logic [3:0] status_d;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) status_d <= '0;
        else          status_d <= {pll_locked, Dash, Dot, PTT};
    assign trig = run && (wrap || ({pll_locked, Dash, Dot, PTT} != status_d) || |(ADC_overload & ~ovl));
`else
    assign trig = run && wrap;
`endif

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= next;

    always_comb begin
        next         = state;
        tx_request   = 1'b0;
        udp_tx_valid = 1'b0;
        udp_tx_last  = 1'b0;
        grab         = 1'b0;
        case (state)
            IDLE:    if (run && pending) next = REQUEST;
            REQUEST: begin
                tx_request = 1'b1;
                if (tx_grant) begin
                    grab = 1'b1;
                    next = SEND;
                end else if (!run) next = IDLE;
            end
            SEND: begin
                udp_tx_valid = 1'b1;
                udp_tx_last  = idx == IW'(PKT_LEN - 1);
                if (udp_tx_last) next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_comb begin
        udp_tx_data = 8'h00;
        if (udp_tx_valid)
            case (int'(idx))
                0:  udp_tx_data = seq[31:24];
                1:  udp_tx_data = seq[23:16];
                2:  udp_tx_data = seq[15:8];
                3:  udp_tx_data = seq[7:0];
                4:  udp_tx_data = status_s;
                5:  udp_tx_data = ovl_s;
                6:  udp_tx_data = exc_s[15:8];
                7:  udp_tx_data = exc_s[7:0];
                14: udp_tx_data = fwd_s[15:8];
                15: udp_tx_data = fwd_s[7:0];
                22: udp_tx_data = rev_s[15:8];
                23: udp_tx_data = rev_s[7:0];
                49: udp_tx_data = volts_s[15:8];
                50: udp_tx_data = volts_s[7:0];
                59: udp_tx_data = user_s;
                default: udp_tx_data = 8'h00;
            endcase
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            timer    <= '0;
            idx      <= '0;
            seq      <= '0;
            ovl      <= '0;
            pending  <= 1'b0;
            run_d    <= 1'b0;
            ovl_s    <= '0;
            status_s <= '0;
            user_s   <= '0;
            exc_s    <= '0;
            fwd_s    <= '0;
            rev_s    <= '0;
            volts_s  <= '0;
        end else begin
            run_d   <= run;
            timer   <= (!run || wrap) ? '0 : timer + 1'b1;
            // a new trigger wins over the grant clear so one packet stays queued
            pending <= trig ? 1'b1 : (grab || !run) ? 1'b0 : pending;
            ovl     <= (grab ? 8'h00 : ovl) | ADC_overload;
            idx     <= grab ? '0 : udp_tx_valid ? idx + 1'b1 : idx;
            seq     <= (run && !run_d) ? '0 : udp_tx_last ? seq + 1'b1 : seq;
            if (grab) begin
                status_s <= {3'b000, pll_locked, 1'b0, Dash, Dot, PTT};
                ovl_s    <= ovl;
                exc_s    <= exciter_power;
                fwd_s    <= FWD_power;
                rev_s    <= REV_power;
                volts_s  <= supply_volts;
                user_s   <= user_inputs;
            end
        end
endmodule

// File: tb/tb_high_priority_status_tx.sv
// tb_high_priority_status_tx: directed checks of packet timing, field layout, sticky overload and run gating.
module tb_high_priority_status_tx;
    localparam int PER = 200;

    logic        clock = 0, reset_n = 0, run = 0, PTT = 0, Dot = 0, Dash = 0, pll_locked = 0, tx_grant = 0;
    logic [7:0]  ADC_overload = 0, user_inputs = 0;
    logic [15:0] exciter_power = 0, FWD_power = 0, REV_power = 0, supply_volts = 0;
    logic        tx_request, udp_tx_valid, udp_tx_last;
    logic [15:0] to_port, udp_tx_length;
    logic [7:0]  udp_tx_data;
    logic [7:0]  exp_pkt [60];
    int          total = 0, bad = 0, cyc = 0, c0, r1, r2, r;
    logic        seen;

    high_priority_status_tx #(.PERIOD(PER)) dut (
        .clock(clock), .reset_n(reset_n), .run(run), .PTT(PTT), .Dot(Dot), .Dash(Dash),
        .pll_locked(pll_locked), .ADC_overload(ADC_overload), .exciter_power(exciter_power),
        .FWD_power(FWD_power), .REV_power(REV_power), .supply_volts(supply_volts),
        .user_inputs(user_inputs), .tx_request(tx_request), .tx_grant(tx_grant),
        .to_port(to_port), .udp_tx_length(udp_tx_length), .udp_tx_data(udp_tx_data),
        .udp_tx_valid(udp_tx_valid), .udp_tx_last(udp_tx_last)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task build(input logic [31:0] s, input logic [7:0] o);
        foreach (exp_pkt[i]) exp_pkt[i] = 8'h00;
        {exp_pkt[0], exp_pkt[1], exp_pkt[2], exp_pkt[3]} = s;
        exp_pkt[4] = {3'b000, pll_locked, 1'b0, Dash, Dot, PTT};
        exp_pkt[5] = o;
        {exp_pkt[6], exp_pkt[7]}   = exciter_power;
        {exp_pkt[14], exp_pkt[15]} = FWD_power;
        {exp_pkt[22], exp_pkt[23]} = REV_power;
        {exp_pkt[49], exp_pkt[50]} = supply_volts;
        exp_pkt[59] = user_inputs;
    endtask

    task wait_req(output int at);
        at = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (tx_request) begin
                at = cyc;
                break;
            end
        end
        check("req_timeout", 32'(at >= 0), 1);
    endtask

    task take_pkt(input string tag);
        @(negedge clock);
        @(negedge clock);
        tx_grant = 1;
        @(negedge clock);
        tx_grant = 0;
        check({tag, "_req_drop"}, tx_request, 0);
        for (int i = 0; i < 60; i++) begin
            check($sformatf("%s_b%0d", tag, i), udp_tx_data, exp_pkt[i]);
            check($sformatf("%s_ctl%0d", tag, i), {udp_tx_valid, udp_tx_last}, {1'b1, i == 59});
            @(negedge clock);
        end
        check({tag, "_end"}, udp_tx_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        PTT = 1; pll_locked = 1; FWD_power = 16'h1234; supply_volts = 16'hABCD; user_inputs = 8'h5A;
        exciter_power = 16'h0102; REV_power = 16'h0F0E;
        #1;
        check("rst_req", tx_request, 0);
        check("rst_valid", udp_tx_valid, 0);
        check("rst_last", udp_tx_last, 0);
        check("rst_data", udp_tx_data, 0);
        check("to_port", to_port, 1025);
        check("length", udp_tx_length, 60);
        repeat (3) @(negedge clock);
        reset_n = 1;
        @(negedge clock);
        tx_grant = 1;
        @(negedge clock);
        tx_grant = 0;
        check("stray_grant_valid", udp_tx_valid, 0);
        check("stray_grant_req", tx_request, 0);
        run = 1;
        c0 = cyc;
        wait_req(r1);
        check("first_req_lat", r1 - c0, 201);
        build(0, 0);
        take_pkt("p0");
        wait_req(r2);
        check("period", r2 - r1, PER);
        build(1, 0);
        take_pkt("p1");
        @(negedge clock);
        ADC_overload = 8'h04;
        @(negedge clock);
        ADC_overload = 8'h00;
        wait_req(r);
        build(2, 8'h04);
        take_pkt("p2");
        wait_req(r);
        build(3, 8'h00);
        take_pkt("p3");
        wait_req(r);
        run = 0;
        @(negedge clock);
        check("gate_drop", tx_request, 0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            seen |= udp_tx_valid | tx_request;
        end
        check("gate_quiet", seen, 0);
        run = 1;
        c0 = cyc;
        wait_req(r);
        check("rerun_lat", r - c0, 201);
        build(0, 0);
        take_pkt("p4");
        repeat (5) @(negedge clock);
        Dot = 1;
        @(negedge clock);
        check("ev_t1", tx_request, 0);
`ifdef HP_STATUS_EVENT_EN
        @(negedge clock);
        check("ev_t2", tx_request, 1);
        build(1, 0);
        take_pkt("ev");
`else
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            seen |= tx_request;
        end
        check("ev_none", seen, 0);
`endif
        wait_req(r);
        @(negedge clock);
        @(negedge clock);
        tx_grant = 1;
        @(negedge clock);
        tx_grant = 0;
        repeat (10) @(negedge clock);
        check("mid_valid", udp_tx_valid, 1);
        reset_n = 0;
        #1;
        check("mid_rst_valid", udp_tx_valid, 0);
        check("mid_rst_data", udp_tx_data, 0);
        check("mid_rst_last", udp_tx_last, 0);
        check("mid_rst_req", tx_request, 0);
        @(negedge clock);
        reset_n = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
